dmem_responder: RTL and testbench

- Memory-side responder for the core's data load/store port: the target end of the request the core issues for ld/sd-class instructions.
- Holds a synthesizable word-addressed data array and serves one request at a time with a fixed, parameterized latency.
- Returns full 64-bit words plus a one-cycle completion pulse, which the core uses as its memory-finish indication.
- Byte selection, sign extension and alignment of loaded data stay on the core side.

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory target for the core's load/store port: one request in flight, fixed LATENCY.
// Optional macro DMEM_RESPONDER_RANGE_CHECK_EN flags and suppresses accesses outside the array window.
module dmem_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [63:0]             mem [DEPTH];

  logic                    wen_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [63:0]             wdata_q;
  logic [7:0]              wmask_q;
  logic                    oor_q;

  logic [63:0]             offset;
  logic [DEPTH_LOG2-1:0]   idx_in;
  logic                    oor_in;
  logic                    unused_ok;

  assign offset = req_addr - BASE_ADDR;
  assign idx_in = offset[DEPTH_LOG2+2:3];

`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
  // Any bit above the window means out of range, which also catches wrapped negative offsets.
  assign oor_in    = |offset[63:DEPTH_LOG2+3];
  assign unused_ok = ^offset[2:0];
`else
  assign oor_in    = 1'b0;
  assign unused_ok = ^{offset[63:DEPTH_LOG2+3], offset[2:0]};
`endif

  logic accept, go_resp, from_req;
  logic                  c_wen, c_oor;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [63:0]           c_wdata;
  logic [7:0]            c_wmask;

  assign accept   = req_valid && req_ready;
  assign go_resp  = (accept && (LATENCY == 1)) || (state == BUSY && cnt == 4'd1);
  // With LATENCY==1 the commit happens on the accepting edge, so take the live request fields.
  assign from_req = (state == IDLE);
  assign c_wen    = from_req ? req_wen   : wen_q;
  assign c_oor    = from_req ? oor_in    : oor_q;
  assign c_idx    = from_req ? idx_in    : idx_q;
  assign c_wdata  = from_req ? req_wdata : wdata_q;
  assign c_wmask  = from_req ? req_wmask : wmask_q;

  // Array is never reset; byte-enabled write on the commit edge.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && c_wen && !c_oor) begin
      for (int b = 0; b < 8; b++) begin
        if (c_wmask[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'h0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
      wen_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 64'h0;
      wmask_q    <= 8'h0;
      oor_q      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wen_q     <= req_wen;
            idx_q     <= idx_in;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            oor_q     <= oor_in;
            req_ready <= 1'b0;
            if (LATENCY != 1) begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd1) cnt <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (go_resp) begin
        state      <= RESP;
        req_ready  <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= c_oor;
        resp_rdata <= (c_wen || c_oor) ? 64'h0 : mem[c_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances (LATENCY 2, 1, 15, 4) driven by directed steps.
// Honors DMEM_RESPONDER_RANGE_CHECK_EN to pick the out-of-range expectations.
module tb_dmem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DL2  = 10;
`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst, req_valid;
  logic        req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic [3:0]  req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 4;
    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] mdl [int];
  int          compared = 0, mismatched = 0, cyc = 0;
  int          resp_cyc [4] = '{default: 0};
  int          resp_cnt [4] = '{default: 0};
  logic [63:0] last_rdata [4];
  logic        last_err [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: per-instance word model keyed by inst*4096+index; expectation queued at drive time.
  task automatic push_exp(input int i, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] mask);
    logic [63:0] off, w;
    int          key;
    bit          oor;
    exp_t        e;
    off = addr - BASE;
    key = i * 4096 + int'(off[DL2+2:3]);
    oor = RC && (off >= 64'(1 << (DL2 + 3)));
    e.inst = i;
    e.err  = oor;
    if (wen) begin
      e.rdata = 64'h0;
      if (!oor) begin
        w = mdl.exists(key) ? mdl[key] : 64'h0;
        for (int b = 0; b < 8; b++) if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mdl[key] = w;
      end
    end else begin
      e.rdata = oor ? 64'h0 : mdl[key];
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (resp_valid[i] === 1'b1) begin
        exp_t e;
        resp_cyc[i]   = cyc;
        resp_cnt[i]   = resp_cnt[i] + 1;
        last_rdata[i] = resp_rdata[i];
        last_err[i]   = resp_err[i];
        chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_inst", 64'(i), 64'(e.inst));
          chk("resp_rdata", resp_rdata[i], e.rdata);
          chk("resp_err", 64'(resp_err[i]), 64'(e.err));
        end
      end
    end
  end

  // acc = cycle count at the negedge just before the accepting edge.
  task automatic issue(input int i, input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] mask, input bit track, output int acc);
    int n = 0;
    @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    req_valid[i] = 1'b1;
    if (track) push_exp(i, wen, addr, wdata, mask);
    while (req_ready[i] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 64), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((exp_q.size() != 0 || req_ready[i] !== 1'b1) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 64), 64'd1);
  endtask

  task automatic hold_run(input int i, input int iters, input int spacing, input logic [63:0] addr,
                          input logic [63:0] wdata);
    int accs [$];
    int c0;
    c0 = resp_cnt[i];
    @(negedge clk);
    req_wen = 1'b1; req_addr = addr; req_wdata = wdata; req_wmask = 8'hFF;
    req_valid[i] = 1'b1;
    for (int k = 0; k < iters; k++) begin
      if (req_ready[i] === 1'b1) begin
        accs.push_back(cyc);
        push_exp(i, 1'b1, addr, wdata, 8'hFF);
      end
      @(negedge clk);
    end
    req_valid[i] = 1'b0;
    chk("hold_accepts", 64'(accs.size() >= 2), 64'd1);
    for (int k = 1; k < accs.size(); k++) chk("hold_spacing", 64'(accs[k] - accs[k-1]), 64'(spacing));
    wait_idle(i);
    chk("one_resp_per_accept", 64'(resp_cnt[i] - c0), 64'(accs.size()));
  endtask

  initial begin
    int a, t;
    rst = 4'hF; req_valid = 4'h0;
    req_wen = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; req_wmask = 8'h0;
    repeat (2) @(posedge clk);
    #1 rst = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_ready", 64'(req_ready[i]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
      chk("rst_rdata", resp_rdata[i], 64'h0);
      chk("rst_err", 64'(resp_err[i]), 64'd0);
    end

    // Store round trip at LATENCY=2 with timing of ready/valid around it.
    issue(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, a);
    @(negedge clk); chk("busy_ready_low", 64'(req_ready[0]), 64'd0);
    @(negedge clk); chk("resp_valid_l2", 64'(resp_valid[0]), 64'd1);
                    chk("resp_ready_low", 64'(req_ready[0]), 64'd0);
    @(negedge clk); chk("ready_back", 64'(req_ready[0]), 64'd1);
                    chk("resp_valid_drop", 64'(resp_valid[0]), 64'd0);
                    chk("latency_l2", 64'(resp_cyc[0] - a), 64'd2);
    issue(0, 1'b0, 64'h8000_0014, 64'h0, 8'h0, 1'b1, a);
    wait_idle(0);
    chk("load_roundtrip", last_rdata[0], 64'h1122_3344_5566_7788);

    // Byte-mask merge, then a zero-mask store that must not disturb the word.
    issue(0, 1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, a);
    issue(0, 1'b1, 64'h8000_0020, 64'h0000_0000_00AB_0000, 8'b0000_0100, 1'b1, a);
    issue(0, 1'b0, 64'h8000_0020, 64'h0, 8'h0, 1'b1, a);
    wait_idle(0);
    chk("mask_merge", last_rdata[0], 64'hFFFF_FFFF_FFAB_FFFF);
    issue(0, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b1, a);
    issue(0, 1'b0, 64'h8000_0010, 64'h0, 8'h0, 1'b1, a);
    wait_idle(0);
    chk("mask_zero", last_rdata[0], 64'h1122_3344_5566_7788);

    // Continuous req_valid: accept spacing is LATENCY+1.
    hold_run(1, 10, 2, 64'h8000_0040, 64'h0123_4567_89AB_CDEF);
    hold_run(2, 40, 16, 64'h8000_0048, 64'hA5A5_5A5A_A5A5_5A5A);

    // Reset two cycles into a LATENCY=4 store: no response, word keeps old contents.
    issue(3, 1'b1, 64'h8000_0000, 64'h5555, 8'hFF, 1'b1, a);
    issue(3, 1'b1, 64'h8000_0000, 64'hDEAD, 8'hFF, 1'b0, a);
    @(negedge clk);
    @(negedge clk); rst[3] = 1'b1;
    @(negedge clk); rst[3] = 1'b0;
    t = resp_cnt[3];
    repeat (6) @(negedge clk);
    chk("abort_no_resp", 64'(resp_cnt[3] - t), 64'd0);
    chk("abort_ready", 64'(req_ready[3]), 64'd1);
    issue(3, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b1, a);
    wait_idle(3);
    chk("abort_keeps_old", last_rdata[3], 64'h5555);

    // Address one word below BASE: flagged with the range check, aliases to the top word without.
    issue(0, 1'b1, 64'h8000_1FF8, 64'hCAFE_F00D_0000_1234, 8'hFF, 1'b1, a);
    issue(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h0, 1'b1, a);
    wait_idle(0);
    chk("oor_err", 64'(last_err[0]), 64'(RC));
    chk("oor_rdata", last_rdata[0], RC ? 64'h0 : 64'hCAFE_F00D_0000_1234);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
